prog_sequencer: RTL and testbench
=================================

# prog_sequencer

Program-level controller for the instruction-fetch unit. It turns the bench's `Start` handshake and the decoder's `Halt` indication into fetch-unit controls. Those controls hold the PC, load the program base address as an absolute jump, and release it to run. It tracks which of up to four programs is active, reports completion through `Done`, and counts execution cycles. It sits between the top-level bench interface and the `InstFetch` `Start`/`BranchAbs`/`Target` inputs; the core decoder's branch logic drives the fetch unit only while this block is in RUN.

## Interface
- `NUM_PROGS`, 3: number of programs in the series, range 1–4.
- `PC_W`, 10: program-counter width.
- `CNT_W`, 16: cycle-counter width.
- `BASE0`, `BASE1`, `BASE2`, `BASE3`, defaults 10'h000, 10'h100, 10'h200, 10'h300: start address of each program.

Ports:
- `Clk` in 1: single clock; all state changes on the rising edge.
- `Reset` in 1: asynchronous, active-low reset. Asserting it (low) forces every register to its reset value immediately.
- `Start` in 1: bench request; a program launches when `Start` is released.
- `Halt` in 1: decoder indicates that the current instruction is the program-end instruction.
- `FetchHold` out 1: drives `InstFetch.Start`; the PC holds while it is 1.
- `FetchLoad` out 1: drives `InstFetch.BranchAbs`, ORed with the decoder's absolute jump.
- `LoadTarget` out PC_W: base address for the current program; muxed onto `InstFetch.Target` while `FetchLoad`=1.
- `ProgNum` out 2: index of the current or next program.
- `Busy` out 1: 1 in LOAD and RUN.
- `Done` out 1: 1 in DONE.
- `CycleCount` out CNT_W: number of RUN cycles in the current or last program.

## Operation
- The FSM states are IDLE, ARMED, LOAD, RUN and DONE. The state is one-hot or binary; it is an implementer's choice and is not observable.
- All outputs are registered or decoded from registers only. No output has a combinational path from `Start` or `Halt`.
- Transitions:
  - IDLE: goes to ARMED when `Start`=1.
  - ARMED: goes to LOAD when `Start`=0; otherwise stays.
  - LOAD: goes to RUN unconditionally after 1 cycle.
  - RUN: goes to ARMED if `Start`=1 (abort/restart). Otherwise it goes to DONE if `Halt`=1. Otherwise it stays.
  - DONE: goes to ARMED when `Start`=1.
- Outputs by state:
  - IDLE, ARMED, DONE: `FetchHold`=1, `FetchLoad`=0.
  - LOAD: `FetchHold`=0, `FetchLoad`=1.
  - RUN: `FetchHold`=0, `FetchLoad`=0.
- `LoadTarget` equals BASE[`ProgNum`] at all times.
- `ProgNum` advances on the RUN→DONE transition only. It wraps from NUM_PROGS−1 to 0. An abort (RUN→ARMED) leaves it unchanged, so the same program restarts.
- `CycleCount` behaviour:
  - Clears to 0 on the cycle that enters LOAD.
  - Increments by 1 on every clock edge where the state is RUN, including the edge that samples `Halt`.
  - Saturates at all-ones; it does not wrap.
  - Holds its value in all other states.
- `Halt` is ignored outside RUN. `Start` asserted in LOAD is ignored; it is seen next cycle in RUN and causes an abort.
- If `Start` and `Halt` are both 1 in RUN, `Start` wins: the next state is ARMED, `ProgNum` is unchanged and `Done` stays 0.

## Timing
- Reset values: state IDLE, `FetchHold`=1, `FetchLoad`=0, `ProgNum`=0, `LoadTarget`=BASE0, `Busy`=0, `Done`=0, `CycleCount`=0.
- Reset deassertion is synchronised by the top level. A reset during RUN returns the block to IDLE immediately, with `ProgNum` set to 0.
- Launch sequence relative to the edge that samples `Start`=0 (edge E):
  - `FetchLoad`=1 in the cycle after E.
  - The PC equals the base address after edge E+1.
  - The first instruction at the base executes in the RUN cycle following that.
- `Halt` sampled at edge H:
  - `Done`=1 and `FetchHold`=1 from H onward.
  - `ProgNum` is incremented at H.
  - The PC advances at most one past the halt instruction and then holds.
- Minimum `Start` pulse is 1 cycle; `Start` may be held for any length of time.

## Test plan
- Reset with `Start`=0 for 5 cycles → IDLE; `FetchHold`=1, `ProgNum`=0, `LoadTarget`=10'h000, `Done`=0, `CycleCount`=0.
- `Start` high 2 cycles then low, `Halt` pulsed on the 7th RUN cycle → `FetchLoad` high for exactly 1 cycle; `Busy` high through RUN; then `Done`=1, `CycleCount`=7, `ProgNum`=1, `LoadTarget`=10'h100.
- Three full programs back-to-back → `ProgNum` goes 0→1→2→0. `LoadTarget` at each LOAD is 10'h000, 10'h100, then 10'h200.
- `Start` reasserted during RUN of program 1 → returns to ARMED; on release, LOAD with `LoadTarget`=10'h100; `CycleCount` is cleared.
- `Start` and `Halt` both 1 in the same RUN cycle → ARMED, `Done`=0, `ProgNum` unchanged. `Halt` pulsed while in IDLE or DONE → no change.
- `Reset` asserted mid-RUN, asynchronous to `Clk` → outputs return to their reset values before the next clock edge. `CycleCount` saturation check with CNT_W=4 and 20 RUN cycles → `CycleCount`=4'hF.

Source files
------------

// File: rtl/prog_sequencer.sv
// Program-level controller for the instruction-fetch unit: arms on Start, launches on its release,
// loads the program base address, runs until Halt, and counts RUN cycles per program.
module prog_sequencer #(
    parameter int              NUM_PROGS = 3,
    parameter int              PC_W      = 10,
    parameter int              CNT_W     = 16,
    parameter logic [PC_W-1:0] BASE0     = 10'h000,
    parameter logic [PC_W-1:0] BASE1     = 10'h100,
    parameter logic [PC_W-1:0] BASE2     = 10'h200,
    parameter logic [PC_W-1:0] BASE3     = 10'h300
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt,
    output logic             FetchHold,
    output logic             FetchLoad,
    output logic [PC_W-1:0]  LoadTarget,
    output logic [1:0]       ProgNum,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCount
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] LAST_PROG = 2'(NUM_PROGS - 1);

    state_t           state_q, state_d;
    logic [1:0]       prog_q, prog_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d = state_q;
        prog_d  = prog_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (Start) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (!Start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                // Start outranks Halt: an abort restarts the same program.
                if (Start) begin
                    state_d = S_ARMED;
                end else if (Halt) begin
                    state_d = S_DONE;
                    prog_d  = (prog_q == LAST_PROG) ? 2'd0 : prog_q + 2'd1;
                end
            end
            S_DONE: begin
                if (Start) state_d = S_ARMED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            prog_q  <= 2'd0;
            cnt_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
            state_q <= state_d;
            prog_q  <= prog_d;
            cnt_q   <= cnt_d;
        end
    end

    // Every output is decoded from registers only; nothing combinational from Start or Halt.
    always_comb begin
        LoadTarget = BASE0;
        unique case (prog_q)
            2'd0: LoadTarget = BASE0;
            2'd1: LoadTarget = BASE1;
            2'd2: LoadTarget = BASE2;
            2'd3: LoadTarget = BASE3;
            default: LoadTarget = BASE0;
        endcase
    end

    assign FetchHold  = (state_q == S_IDLE) || (state_q == S_ARMED) || (state_q == S_DONE);
    assign FetchLoad  = (state_q == S_LOAD);
    assign Busy       = (state_q == S_LOAD) || (state_q == S_RUN);
    assign Done       = (state_q == S_DONE);
    assign ProgNum    = prog_q;
    assign CycleCount = cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: directed table, hand sequences for abort/reset/saturation,
// and random Start/Halt traffic compared against a behavioural model.
module tb_prog_sequencer;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic        Halt;

    logic        fetch_hold, fetch_load, busy, done;
    logic [9:0]  load_target;
    logic [1:0]  prog_num;
    logic [15:0] cycle_count;

    logic        fetch_hold4, fetch_load4, busy4, done4;
    logic [9:0]  load_target4;
    logic [1:0]  prog_num4;
    logic [3:0]  cycle_count4;

    prog_sequencer dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt),
        .FetchHold(fetch_hold), .FetchLoad(fetch_load), .LoadTarget(load_target),
        .ProgNum(prog_num), .Busy(busy), .Done(done), .CycleCount(cycle_count)
    );

    prog_sequencer #(.CNT_W(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt),
        .FetchHold(fetch_hold4), .FetchLoad(fetch_load4), .LoadTarget(load_target4),
        .ProgNum(prog_num4), .Busy(busy4), .Done(done4), .CycleCount(cycle_count4)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: the program-level rules stated directly.
    typedef enum {M_IDLE, M_ARMED, M_LOAD, M_RUN, M_DONE} mstate_t;
    mstate_t m_st;
    int      m_prog;
    int      m_cnt;
    localparam int NUM_PROGS = 3;

    function automatic int base_of(input int p);
        return p * 256;
    endfunction

    task automatic model_reset();
        m_st   = M_IDLE;
        m_prog = 0;
        m_cnt  = 0;
    endtask

    task automatic model_step(input logic s, input logic h);
        case (m_st)
            M_IDLE:  if (s) m_st = M_ARMED;
            M_ARMED: if (!s) begin m_st = M_LOAD; m_cnt = 0; end
            M_LOAD:  m_st = M_RUN;
            M_RUN: begin
                m_cnt++;
                if (s) m_st = M_ARMED;
                else if (h) begin
                    m_st   = M_DONE;
                    m_prog = (m_prog + 1) % NUM_PROGS;
                end
            end
            M_DONE:  if (s) m_st = M_ARMED;
            default: m_st = M_IDLE;
        endcase
    endtask

    task automatic check_model(input string tag);
        int exp16, exp4;
        exp16 = (m_cnt > 65535) ? 65535 : m_cnt;
        exp4  = (m_cnt > 15) ? 15 : m_cnt;
        check({tag, " hold"},   32'(fetch_hold),  32'(m_st inside {M_IDLE, M_ARMED, M_DONE}));
        check({tag, " load"},   32'(fetch_load),  32'(m_st == M_LOAD));
        check({tag, " busy"},   32'(busy),        32'(m_st inside {M_LOAD, M_RUN}));
        check({tag, " done"},   32'(done),        32'(m_st == M_DONE));
        check({tag, " prog"},   32'(prog_num),    32'(m_prog));
        check({tag, " target"}, 32'(load_target), 32'(base_of(m_prog)));
        check({tag, " cnt"},    32'(cycle_count), 32'(exp16));
        check({tag, " cnt4"},   32'(cycle_count4), 32'(exp4));
        check({tag, " hold4"},  32'(fetch_hold4), 32'(fetch_hold));
    endtask

    // Drive one cycle of inputs, clock it, and sample 1 time unit after the edge.
    task automatic tick(input logic s, input logic h, input string tag);
        Start = s;
        Halt  = h;
        @(posedge Clk);
        #1;
        model_step(s, h);
        check_model(tag);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " hold"},   32'(fetch_hold),  32'd1);
        check({tag, " load"},   32'(fetch_load),  32'd0);
        check({tag, " busy"},   32'(busy),        32'd0);
        check({tag, " done"},   32'(done),        32'd0);
        check({tag, " prog"},   32'(prog_num),    32'd0);
        check({tag, " target"}, 32'(load_target), 32'h000);
        check({tag, " cnt"},    32'(cycle_count), 32'd0);
        check({tag, " cnt4"},   32'(cycle_count4), 32'd0);
    endtask

    // Start pulse then release: ends with the DUT in LOAD.
    task automatic launch(input string tag);
        tick(1'b1, 1'b0, {tag, " arm"});
        tick(1'b0, 1'b0, {tag, " load"});
    endtask

    typedef struct {
        logic        start;
        logic        halt;
        logic        hold;
        logic        load;
        logic        busy;
        logic        done;
        logic [1:0]  prog;
        logic [15:0] cnt;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic h, input logic ho, input logic lo,
                                input logic bu, input logic dn, input logic [1:0] p,
                                input logic [15:0] c);
        vec_t v;
        v.start = s; v.halt = h; v.hold = ho; v.load = lo;
        v.busy = bu; v.done = dn; v.prog = p; v.cnt = c;
        return v;
    endfunction

    vec_t vecs[13];

    initial begin
        logic [9:0] exp_tgt [3];
        logic [1:0] exp_prog_after [3];

        vecs[0] = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
        vecs[1] = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
        vecs[2] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 16'd0);
        vecs[3] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0);
        for (int k = 1; k <= 6; k++)
            vecs[3 + k] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'(k));
        vecs[10] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 16'd7);
        vecs[11] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 16'd7);
        vecs[12] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 16'd7);

        exp_tgt[0] = 10'h000; exp_tgt[1] = 10'h100; exp_tgt[2] = 10'h200;
        exp_prog_after[0] = 2'd1; exp_prog_after[1] = 2'd2; exp_prog_after[2] = 2'd0;

        // Reset held for 5 cycles with Start low.
        Reset = 1'b0;
        Start = 1'b0;
        Halt  = 1'b0;
        model_reset();
        repeat (5) @(posedge Clk);
        #1;
        check_reset_values("reset");
        Reset = 1'b1;

        // Directed launch / 7-cycle run / halt, checked against the table.
        for (int i = 0; i < 13; i++) begin
            Start = vecs[i].start;
            Halt  = vecs[i].halt;
            @(posedge Clk);
            #1;
            model_step(vecs[i].start, vecs[i].halt);
            check($sformatf("vec%0d hold", i),   32'(fetch_hold),  32'(vecs[i].hold));
            check($sformatf("vec%0d load", i),   32'(fetch_load),  32'(vecs[i].load));
            check($sformatf("vec%0d busy", i),   32'(busy),        32'(vecs[i].busy));
            check($sformatf("vec%0d done", i),   32'(done),        32'(vecs[i].done));
            check($sformatf("vec%0d prog", i),   32'(prog_num),    32'(vecs[i].prog));
            check($sformatf("vec%0d cnt", i),    32'(cycle_count), 32'(vecs[i].cnt));
            check($sformatf("vec%0d target", i), 32'(load_target), 32'(vecs[i].prog) * 32'd256);
        end

        // Back-to-back programs from a fresh reset: 0 -> 1 -> 2 -> 0.
        #2 Reset = 1'b0;
        #1;
        model_reset();
        check_reset_values("reset2");
        @(posedge Clk);
        #1 Reset = 1'b1;
        tick(1'b0, 1'b1, "halt_idle");
        for (int p = 0; p < 3; p++) begin
            launch($sformatf("prog%0d", p));
            check($sformatf("prog%0d load_target", p), 32'(load_target), 32'(exp_tgt[p]));
            tick(1'b0, 1'b0, "run");
            repeat (3) tick(1'b0, 1'b0, "run");
            tick(1'b0, 1'b1, "halt");
            check($sformatf("prog%0d next", p), 32'(prog_num), 32'(exp_prog_after[p]));
        end

        // Abort during program 1, then Start+Halt collision.
        launch("p0");
        tick(1'b0, 1'b0, "p0 run");
        tick(1'b0, 1'b1, "p0 halt");
        launch("p1");
        repeat (5) tick(1'b0, 1'b0, "p1 run");
        tick(1'b1, 1'b0, "abort");
        check("abort prog", 32'(prog_num), 32'd1);
        check("abort busy", 32'(busy), 32'd0);
        tick(1'b0, 1'b0, "relaunch");
        check("relaunch target", 32'(load_target), 32'h100);
        check("relaunch cnt", 32'(cycle_count), 32'd0);
        tick(1'b0, 1'b0, "p1 run");
        tick(1'b0, 1'b0, "p1 run");
        tick(1'b1, 1'b1, "collide");
        check("collide done", 32'(done), 32'd0);
        check("collide prog", 32'(prog_num), 32'd1);
        tick(1'b0, 1'b0, "p1 load");
        tick(1'b0, 1'b0, "p1 run");
        tick(1'b0, 1'b1, "p1 halt");
        tick(1'b0, 1'b1, "halt_done");
        tick(1'b0, 1'b1, "halt_done");
        check("halt_done prog", 32'(prog_num), 32'd2);

        // Asynchronous reset in the middle of RUN.
        launch("p2");
        repeat (4) tick(1'b0, 1'b0, "p2 run");
        #2 Reset = 1'b0;
        #1;
        model_reset();
        check_reset_values("async_reset");
        @(posedge Clk);
        #1 Reset = 1'b1;

        // Saturation of the 4-bit counter over 20 RUN cycles.
        launch("sat");
        tick(1'b0, 1'b0, "sat run");
        repeat (20) tick(1'b0, 1'b0, "sat run");
        check("sat cnt4", 32'(cycle_count4), 32'hF);
        check("sat cnt16", 32'(cycle_count), 32'd20);
        tick(1'b0, 1'b1, "sat halt");

        // Random Start/Halt traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic s, h;
            s = ($urandom_range(0, 99) < 15);
            h = ($urandom_range(0, 99) < 12);
            tick(s, h, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
